mac_op_sequencer: RTL and testbench
===================================

Name: mac_op_sequencer

Overview:
- Front-end controller for the configurable MAC datapath: negator block, partial-product multiplier and accumulator.
- Accepts a valid/ready stream of operand beats tagged with a 4-bit cfg and a group-last flag, and drives the datapath's en, cfg, operands and accumulator-clear.
- Tracks in-flight beats in a valid/last shadow pipeline and raises a result handshake when a group's last beat exits.
- Drains the pipeline before any cfg change so the negation chain and accumulator never mix modes.

Parameters:
- MAC_CONF_WIDTH, 4, cfg width: [3] signed, [2] mac(1)/mul(0), [1:0] single/dual/quad.
- MAC_MIN_WIDTH, 8, lane width.
- MAC_OPND_WIDTH, 4*MAC_MIN_WIDTH, packed A/B operand width (lanes 3..0).
- MAC_PIPE_DEPTH, 3, datapath latency in enabled cycles (≥1).
- MAC_CNT_WIDTH, 16, beat-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  operand beat valid.
- req_ready  out  1  sequencer accepts beat.
- req_cfg  in  MAC_CONF_WIDTH  beat cfg; sampled on first beat of a group.
- req_a  in  MAC_OPND_WIDTH  packed A0..A3.
- req_b  in  MAC_OPND_WIDTH  packed B0..B3.
- req_last  in  1  last beat of accumulation group (ignored in mul mode; every beat is last).
- dp_en  out  1  datapath pipeline advance.
- dp_cfg  out  MAC_CONF_WIDTH  active cfg to datapath.
- dp_a  out  MAC_OPND_WIDTH  registered A.
- dp_b  out  MAC_OPND_WIDTH  registered B.
- dp_vld  out  1  dp_a/dp_b hold a real beat (else bubble; datapath must not accumulate).
- dp_acc_clr  out  1  first beat of group; accumulator loads instead of adds.
- res_valid  out  1  datapath result for a completed group is at output.
- res_ready  in  1  consumer takes result.
- busy  out  1  any beat in flight or state ≠ IDLE.
- beat_cnt  out  MAC_CNT_WIDTH  beats accepted in current group.
- cfg_err  out  1  sticky: mid-group cfg mismatch seen; cleared only by reset.

Behaviour:
- Reset (rst low, async): state IDLE; req_ready=0; dp_en=0; dp_vld=0; dp_acc_clr=0; dp_a=dp_b=0; dp_cfg=0; res_valid=0; busy=0; beat_cnt=0; cfg_err=0; shadow pipeline cleared. Reset mid-group discards all in-flight beats; no res_valid is produced for them.
- stall = res_valid & ~res_ready.
- dp_en = ~stall.
- The shadow pipeline (MAC_PIPE_DEPTH stages of {vld,last}) shifts only when dp_en=1. res_valid is the tail stage's vld&last.
- Accept a beat when req_valid & req_ready. req_ready = ~stall & (state==RUN | state==IDLE) & no pending cfg switch.
- A beat accepted at cycle t appears on dp_a/dp_b/dp_vld at t+1. Its result is marked at the tail MAC_PIPE_DEPTH enabled cycles later.
- States:
  - IDLE: no open group. On accept, compare req_cfg to dp_cfg.
    - Equal: issue with dp_acc_clr=1 and go to RUN.
    - Different: req_ready drops the same cycle (combinational compare), no issue, go to DRAIN.
  - RUN: group open. Each accepted beat issues with dp_acc_clr=0 and increments beat_cnt (saturating at all-ones). If req_cfg ≠ dp_cfg on a non-first beat, set cfg_err; the beat is still issued with dp_cfg unchanged. A beat with req_last (or any beat in mul mode) closes the group: go to IDLE, beat_cnt ← 0 on the following cycle.
  - DRAIN: req_ready=0; the pipeline keeps shifting bubbles (dp_vld=0). When the shadow pipeline is empty and res_valid=0, go to SWITCH.
  - SWITCH: one cycle; dp_cfg ← latched pending cfg; return to IDLE. The held beat is then accepted normally (settle bubble guarantees ≥1 idle cycle between modes).
- Mul mode: every beat is a group of 1, so dp_acc_clr=1 on every issue.
- Simultaneous: a result handshake and a new accept in the same cycle are allowed. Under stall no accept occurs and the shadow pipeline, dp_* and beat_cnt hold.
- busy = (state≠IDLE) | any shadow vld | res_valid.

Optional Feature:
- Macro MAC_SEQ_PERF_EN.
- Defined: adds outputs perf_busy_cyc and perf_stall_cyc, each 32 bits, wrapping. They count cycles with busy=1 and with stall|DRAIN|SWITCH respectively, and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package mac_const.vh holds:
  - cfg bit indices (CFG_SIGNED=3, CFG_MAC=2) and mode encodings (SINGLE=2'b00, DUAL=2'b01, QUAD=2'b10);
  - state encodings IDLE/RUN/DRAIN/SWITCH.
- One sub-module, mac_seq_shadow_pipe: the parameterized {vld,last} shift register with enable, an empty flag and a tail output.

Test Plan:
- Mul mode, cfg=4'b1000, MAC_PIPE_DEPTH=3: 4 back-to-back beats, res_ready=1 → dp_acc_clr=1 on each issue; res_valid pulses at cycles 4,5,6,7 after the first accept.
- Mac quad signed, cfg=4'b1110: 5-beat group with req_last on beat 5 → dp_acc_clr only on beat 1; beat_cnt counts 1..5; a single res_valid 3 cycles after beat 5 issues.
- Cfg change from 4'b0100 to 4'b1101 with 2 beats in flight → req_ready low; no issue until the pipeline is empty; SWITCH updates dp_cfg; the new beat issues ≥1 cycle after the last old result.
- res_ready=0 for 4 cycles with res_valid=1 → dp_en=0; req_ready=0; dp_a, dp_b, beat_cnt frozen; resumes without loss or duplication.
- Mid-group req_cfg mismatch on beat 2 → cfg_err=1 sticky; dp_cfg unchanged; the group completes normally.
- Assert rst low mid-group with 2 beats in flight → all outputs return to reset values asynchronously; no res_valid after release.

Source files
------------

// File: rtl/mac_op_sequencer_pkg.sv
// Shared constants for the MAC operand sequencer: cfg bit indices,
// lane-mode encodings and sequencer state encodings.
package mac_op_sequencer_pkg;

    localparam int CFG_SIGNED = 3;
    localparam int CFG_MAC    = 2;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_DUAL   = 2'b01;
    localparam logic [1:0] MODE_QUAD   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_SWITCH = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mac_op_sequencer_shadow_pipe.sv
// {vld,last} shadow of the MAC datapath pipeline; shifts only when enabled.
module mac_seq_shadow_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic en_i,
    input  logic vld_i,
    input  logic last_i,
    output logic empty_o,
    output logic tail_vld_o,
    output logic tail_last_o
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] last_q, last_d;

    always_comb begin
        vld_d     = '0;
        last_d    = '0;
        vld_d[0]  = vld_i;
        last_d[0] = last_i;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            last_q <= '0;
        end else if (en_i) begin
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign empty_o     = ~|vld_q;
    assign tail_vld_o  = vld_q[DEPTH-1];
    assign tail_last_o = last_q[DEPTH-1];

endmodule

// File: rtl/mac_op_sequencer.sv
// Front-end sequencer for the configurable MAC datapath.
// Define MAC_SEQ_PERF_EN to add the perf_busy_cyc/perf_stall_cyc counters.
module mac_op_sequencer
    import mac_op_sequencer_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_OPND_WIDTH = 4 * MAC_MIN_WIDTH,
    parameter int MAC_PIPE_DEPTH = 3,
    parameter int MAC_CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [MAC_CONF_WIDTH-1:0] req_cfg,
    input  logic [MAC_OPND_WIDTH-1:0] req_a,
    input  logic [MAC_OPND_WIDTH-1:0] req_b,
    input  logic                      req_last,
    output logic                      dp_en,
    output logic [MAC_CONF_WIDTH-1:0] dp_cfg,
    output logic [MAC_OPND_WIDTH-1:0] dp_a,
    output logic [MAC_OPND_WIDTH-1:0] dp_b,
    output logic                      dp_vld,
    output logic                      dp_acc_clr,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy,
    output logic [MAC_CNT_WIDTH-1:0]  beat_cnt,
`ifdef MAC_SEQ_PERF_EN
    output logic [31:0]               perf_busy_cyc,
    output logic [31:0]               perf_stall_cyc,
`endif
    output logic                      cfg_err
);

    seq_state_e state_q, state_d;

    logic                      alive_q;
    logic [MAC_CONF_WIDTH-1:0] dp_cfg_q, pend_cfg_q, pend_cfg_d;
    logic [MAC_OPND_WIDTH-1:0] dp_a_q, dp_b_q;
    logic                      dp_vld_q, dp_last_q, dp_clr_q;
    logic [MAC_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                      err_q, err_d;

    logic stall, en, issue, first, close, cfg_diff, inflight;
    logic pipe_empty, tail_vld, tail_last;

    mac_seq_shadow_pipe #(
        .DEPTH(MAC_PIPE_DEPTH)
    ) u_shadow (
        .clk         (clk),
        .rst_ni      (rst),
        .en_i        (en),
        .vld_i       (dp_vld_q),
        .last_i      (dp_last_q),
        .empty_o     (pipe_empty),
        .tail_vld_o  (tail_vld),
        .tail_last_o (tail_last)
    );

    assign res_valid = tail_vld & tail_last;
    assign stall     = res_valid & ~res_ready;
    // alive_q keeps ready/enable low while reset is held
    assign en        = ~stall & alive_q;
    assign cfg_diff  = req_cfg != dp_cfg_q;
    assign close     = ~dp_cfg_q[CFG_MAC] | req_last;
    assign inflight  = dp_vld_q | ~pipe_empty;

    always_comb begin
        state_d    = state_q;
        pend_cfg_d = pend_cfg_q;
        req_ready  = 1'b0;
        issue      = 1'b0;
        first      = 1'b0;
        unique case (state_q)
            ST_IDLE: if (en) begin
                if (req_valid && cfg_diff) begin
                    pend_cfg_d = req_cfg;
                    state_d    = ST_DRAIN;
                end else begin
                    req_ready = 1'b1;
                    issue     = req_valid;
                    first     = req_valid;
                    if (req_valid && !close) state_d = ST_RUN;
                end
            end
            ST_RUN: if (en) begin
                req_ready = 1'b1;
                issue     = req_valid;
                if (req_valid && close) state_d = ST_IDLE;
            end
            ST_DRAIN: if (!inflight && !res_valid) state_d = ST_SWITCH;
            ST_SWITCH: state_d = ST_IDLE;
        endcase

        cnt_d = cnt_q;
        if (issue) begin
            if (first)       cnt_d = MAC_CNT_WIDTH'(1);
            else if (~&cnt_q) cnt_d = cnt_q + 1'b1;
        end else if (en && state_q == ST_IDLE) begin
            cnt_d = '0;
        end
        err_d = err_q | (issue & ~first & cfg_diff);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_q    <= 1'b0;
            state_q    <= ST_IDLE;
            pend_cfg_q <= '0;
            dp_cfg_q   <= '0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            dp_vld_q   <= 1'b0;
            dp_last_q  <= 1'b0;
            dp_clr_q   <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            alive_q    <= 1'b1;
            state_q    <= state_d;
            pend_cfg_q <= pend_cfg_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            if (state_q == ST_SWITCH) dp_cfg_q <= pend_cfg_q;
            if (en) begin
                dp_vld_q  <= issue;
                dp_last_q <= issue & close;
                dp_clr_q  <= issue & first;
                if (issue) begin
                    dp_a_q <= req_a;
                    dp_b_q <= req_b;
                end
            end
        end
    end

    assign dp_en      = en;
    assign dp_cfg     = dp_cfg_q;
    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign dp_vld     = dp_vld_q;
    assign dp_acc_clr = dp_clr_q;
    assign beat_cnt   = cnt_q;
    assign cfg_err    = err_q;
    assign busy       = (state_q != ST_IDLE) | inflight | res_valid;

`ifdef MAC_SEQ_PERF_EN
    logic [31:0] pbusy_q, pstall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pbusy_q  <= '0;
            pstall_q <= '0;
        end else begin
            if (busy) pbusy_q <= pbusy_q + 1'b1;
            if (stall || state_q == ST_DRAIN || state_q == ST_SWITCH)
                pstall_q <= pstall_q + 1'b1;
        end
    end

    assign perf_busy_cyc  = pbusy_q;
    assign perf_stall_cyc = pstall_q;
`endif

endmodule

// File: tb/tb_mac_op_sequencer.sv
// Table-driven bench for mac_op_sequencer plus a mid-group reset sequence.
module tb_mac_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_last = 1'b0;
    logic        res_ready = 1'b1;
    logic [3:0]  req_cfg = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;

    logic        req_ready, dp_en, dp_vld, dp_acc_clr, res_valid, busy, cfg_err;
    logic [3:0]  dp_cfg;
    logic [31:0] dp_a, dp_b;
    logic [15:0] beat_cnt;

    always #5 clk = ~clk;

    mac_op_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cfg    (req_cfg),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_last   (req_last),
        .dp_en      (dp_en),
        .dp_cfg     (dp_cfg),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_vld     (dp_vld),
        .dp_acc_clr (dp_acc_clr),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy),
        .beat_cnt   (beat_cnt),
        .cfg_err    (cfg_err)
    );

    typedef struct {
        bit          rs;
        bit          v;
        logic [3:0]  c;
        logic [31:0] a;
        bit          l;
        bit          rr;
        bit          rdy, dpv, clr, rv, bsy, err;
        int          cnt;
        logic [3:0]  cfg;
        logic [31:0] ea;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [31:0] av(input int k);
        return 32'h0403_0201 + 32'h1010_1010 * k;
    endfunction

    function automatic logic [31:0] rot(input logic [31:0] x);
        return {x[7:0], x[31:8]};
    endfunction

    function automatic logic [90:0] outs();
        return {req_ready, dp_en, dp_vld, dp_acc_clr, res_valid, busy,
                cfg_err, beat_cnt, dp_cfg, dp_a, dp_b};
    endfunction

    task automatic check(input string name, input logic [90:0] act,
                         input logic [90:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic add(input bit rs, input bit v, input logic [3:0] c,
                       input logic [31:0] a, input bit l, input bit rr,
                       input bit rdy, input bit dpv, input bit clr,
                       input bit rv, input bit bsy, input bit err,
                       input int cnt, input logic [3:0] cfg,
                       input logic [31:0] ea);
        vec_t t;
        t.rs = rs; t.v = v; t.c = c; t.a = a; t.l = l; t.rr = rr;
        t.rdy = rdy; t.dpv = dpv; t.clr = clr; t.rv = rv;
        t.bsy = bsy; t.err = err; t.cnt = cnt; t.cfg = cfg; t.ea = ea;
        tbl.push_back(t);
    endtask

    // reset, then drain/switch from cfg 0 to c and accept beat A0
    task automatic prelude(input logic [3:0] c);
        add(1, 1, c, av(0), 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
        add(0, 1, c, av(0), 0, 1, 0, 0, 0, 0, 1, 0, 0, 4'h0, 0);
        add(0, 1, c, av(0), 0, 1, 0, 0, 0, 0, 1, 0, 0, 4'h0, 0);
        add(0, 1, c, av(0), 0, 1, 1, 0, 0, 0, 0, 0, 0, c, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 0; req_last = 0; res_ready = 1;
        req_cfg = 0; req_a = 0; req_b = 0;
        rst = 0;
        #1 check("reset_state", outs(), '0);
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [90:0] exp;
        int          n;
        bit          seen;

        // mul mode, back-to-back single-beat groups
        prelude(4'h8);
        add(0, 1, 4'h8, av(1), 0, 1, 1, 1, 1, 0, 1, 0, 1, 4'h8, av(0));
        add(0, 1, 4'h8, av(2), 0, 1, 1, 1, 1, 0, 1, 0, 1, 4'h8, av(1));
        add(0, 1, 4'h8, av(3), 0, 1, 1, 1, 1, 0, 1, 0, 1, 4'h8, av(2));
        add(0, 0, 4'h8, 0,     0, 1, 1, 1, 1, 1, 1, 0, 1, 4'h8, av(3));
        for (int k = 0; k < 3; k++)
            add(0, 0, 4'h8, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 4'h8, av(3));
        add(0, 0, 4'h8, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'h8, av(3));

        // mac quad signed, 5-beat group
        prelude(4'hE);
        add(0, 1, 4'hE, av(1), 0, 1, 1, 1, 1, 0, 1, 0, 1, 4'hE, av(0));
        add(0, 1, 4'hE, av(2), 0, 1, 1, 1, 0, 0, 1, 0, 2, 4'hE, av(1));
        add(0, 1, 4'hE, av(3), 0, 1, 1, 1, 0, 0, 1, 0, 3, 4'hE, av(2));
        add(0, 1, 4'hE, av(4), 1, 1, 1, 1, 0, 0, 1, 0, 4, 4'hE, av(3));
        add(0, 0, 4'hE, 0,     0, 1, 1, 1, 0, 0, 1, 0, 5, 4'hE, av(4));
        add(0, 0, 4'hE, 0,     0, 1, 1, 0, 0, 0, 1, 0, 0, 4'hE, av(4));
        add(0, 0, 4'hE, 0,     0, 1, 1, 0, 0, 0, 1, 0, 0, 4'hE, av(4));
        add(0, 0, 4'hE, 0,     0, 1, 1, 0, 0, 1, 1, 0, 0, 4'hE, av(4));
        add(0, 0, 4'hE, 0,     0, 1, 1, 0, 0, 0, 0, 0, 0, 4'hE, av(4));

        // result back-pressure for 4 cycles
        prelude(4'h8);
        add(0, 1, 4'h8, av(1), 0, 1, 1, 1, 1, 0, 1, 0, 1, 4'h8, av(0));
        add(0, 1, 4'h8, av(2), 0, 1, 1, 1, 1, 0, 1, 0, 1, 4'h8, av(1));
        add(0, 1, 4'h8, av(3), 0, 1, 1, 1, 1, 0, 1, 0, 1, 4'h8, av(2));
        for (int k = 0; k < 4; k++)
            add(0, 1, 4'h8, av(4), 0, 0, 0, 1, 1, 1, 1, 0, 1, 4'h8, av(3));
        add(0, 1, 4'h8, av(4), 0, 1, 1, 1, 1, 1, 1, 0, 1, 4'h8, av(3));
        add(0, 0, 4'h8, 0,     0, 1, 1, 1, 1, 1, 1, 0, 1, 4'h8, av(4));
        for (int k = 0; k < 3; k++)
            add(0, 0, 4'h8, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 4'h8, av(4));
        add(0, 0, 4'h8, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'h8, av(4));

        // cfg change 0100 -> 1101 with 2 beats in flight
        prelude(4'h4);
        add(0, 1, 4'h4, av(1), 1, 1, 1, 1, 1, 0, 1, 0, 1, 4'h4, av(0));
        add(0, 1, 4'hD, av(2), 1, 1, 0, 1, 0, 0, 1, 0, 2, 4'h4, av(1));
        add(0, 1, 4'hD, av(2), 1, 1, 0, 0, 0, 0, 1, 0, 0, 4'h4, av(1));
        add(0, 1, 4'hD, av(2), 1, 1, 0, 0, 0, 0, 1, 0, 0, 4'h4, av(1));
        add(0, 1, 4'hD, av(2), 1, 1, 0, 0, 0, 1, 1, 0, 0, 4'h4, av(1));
        add(0, 1, 4'hD, av(2), 1, 1, 0, 0, 0, 0, 1, 0, 0, 4'h4, av(1));
        add(0, 1, 4'hD, av(2), 1, 1, 0, 0, 0, 0, 1, 0, 0, 4'h4, av(1));
        add(0, 1, 4'hD, av(2), 1, 1, 1, 0, 0, 0, 0, 0, 0, 4'hD, av(1));
        add(0, 0, 4'hD, 0,     0, 1, 1, 1, 1, 0, 1, 0, 1, 4'hD, av(2));
        add(0, 0, 4'hD, 0,     0, 1, 1, 0, 0, 0, 1, 0, 0, 4'hD, av(2));
        add(0, 0, 4'hD, 0,     0, 1, 1, 0, 0, 0, 1, 0, 0, 4'hD, av(2));
        add(0, 0, 4'hD, 0,     0, 1, 1, 0, 0, 1, 1, 0, 0, 4'hD, av(2));
        add(0, 0, 4'hD, 0,     0, 1, 1, 0, 0, 0, 0, 0, 0, 4'hD, av(2));

        // mid-group cfg mismatch on beat 2
        prelude(4'h4);
        add(0, 1, 4'h6, av(1), 0, 1, 1, 1, 1, 0, 1, 0, 1, 4'h4, av(0));
        add(0, 1, 4'h4, av(2), 1, 1, 1, 1, 0, 0, 1, 1, 2, 4'h4, av(1));
        add(0, 0, 4'h4, 0,     0, 1, 1, 1, 0, 0, 1, 1, 3, 4'h4, av(2));
        add(0, 0, 4'h4, 0,     0, 1, 1, 0, 0, 0, 1, 1, 0, 4'h4, av(2));
        add(0, 0, 4'h4, 0,     0, 1, 1, 0, 0, 0, 1, 1, 0, 4'h4, av(2));
        add(0, 0, 4'h4, 0,     0, 1, 1, 0, 0, 1, 1, 1, 0, 4'h4, av(2));
        add(0, 0, 4'h4, 0,     0, 1, 1, 0, 0, 0, 0, 1, 0, 4'h4, av(2));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rs) do_reset();
            @(negedge clk);
            req_valid = tbl[i].v;
            req_cfg   = tbl[i].c;
            req_a     = tbl[i].a;
            req_b     = rot(tbl[i].a);
            req_last  = tbl[i].l;
            res_ready = tbl[i].rr;
            #1;
            exp = {tbl[i].rdy, ~(tbl[i].rv & ~tbl[i].rr), tbl[i].dpv,
                   tbl[i].clr, tbl[i].rv, tbl[i].bsy, tbl[i].err,
                   16'(tbl[i].cnt), tbl[i].cfg, tbl[i].ea, rot(tbl[i].ea)};
            check($sformatf("row%0d", i), outs(), exp);
        end

        // asynchronous reset with two beats of an open group in flight
        do_reset();
        req_valid = 1; req_cfg = 4'h4; req_last = 0;
        req_a = av(5); req_b = rot(av(5));
        n = 0;
        #1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!req_ready) begin
            failures++;
            $display("FAIL ready_timeout got=0 want=1");
        end
        @(negedge clk);
        req_a = av(6); req_b = rot(av(6));
        @(negedge clk);
        req_valid = 0;
        #1 check("busy_before_reset", {90'b0, busy}, 91'd1);
        #1 rst = 0;
        #1 check("async_reset", outs(), '0);
        @(negedge clk);
        rst = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid || busy) seen = 1;
        end
        check("no_result_after_reset", {90'b0, seen}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
